// File: rtl/conv2d_engine.sv
// Naive zero-padded "same" 2D convolution engine behind a single-outstanding valid/ready memory port.
// Optional cycle counter output perf_cycles is enabled by defining CONV2D_PERF_CNT_EN.
module conv2d_engine #(
    parameter int WT_DIM = 3,
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              idle,
    output logic              done,
    input  logic [31:0]       fm_dim,
    input  logic [31:0]       wt_offset,
    input  logic [31:0]       ifm_offset,
    input  logic [31:0]       ofm_offset,
    output logic [AWIDTH-1:0] mem_req_addr,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [DWIDTH-1:0] mem_req_data,
    output logic              mem_req_write,
    input  logic [DWIDTH-1:0] mem_resp_data,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready
`ifdef CONV2D_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int NTAP = WT_DIM * WT_DIM;
    localparam int KW = $clog2(NTAP + 1);
    localparam int MW = $clog2(WT_DIM + 1);
    localparam logic [33:0] HALF = 34'(WT_DIM / 2);
    localparam logic [31:0] HALF32 = 32'(WT_DIM / 2);
    localparam logic [KW-1:0] LAST_TAP = KW'(NTAP - 1);
    localparam logic [MW-1:0] LAST_MN = MW'(WT_DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WT,
        S_COMPUTE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [31:0] fm_q, fm_d;
    logic [31:0] wt_off_q, wt_off_d;
    logic [31:0] ifm_off_q, ifm_off_d;
    logic [31:0] ofm_off_q, ofm_off_d;
    logic [KW-1:0] k_q, k_d;
    logic [MW-1:0] m_q, m_d;
    logic [MW-1:0] n_q, n_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0] wt_q [NTAP];
    logic [DWIDTH-1:0] wt_d [NTAP];
    logic req_valid_q, req_valid_d;
    logic req_write_q, req_write_d;
    logic [AWIDTH-1:0] req_addr_q, req_addr_d;
    logic [DWIDTH-1:0] req_data_q, req_data_d;
    logic resp_ready_q, resp_ready_d;
    logic idle_q, idle_d;
    logic done_q, done_d;
    logic tap_step;

    // Tap coordinates are biased by HALF so that the halo test stays unsigned.
    logic [33:0] ux, uy;
    logic halo;
    logic [31:0] idx, idy;
    logic [AWIDTH-1:0] wt_addr, pix_addr, out_addr;
    logic [DWIDTH-1:0] product;

    assign ux = {2'b00, x_q} + 34'(n_q);
    assign uy = {2'b00, y_q} + 34'(m_q);
    assign halo = (ux < HALF) || ((ux - HALF) >= {2'b00, fm_q}) ||
                  (uy < HALF) || ((uy - HALF) >= {2'b00, fm_q});
    assign idx = x_q + 32'(n_q) - HALF32;
    assign idy = y_q + 32'(m_q) - HALF32;
    assign wt_addr = AWIDTH'(wt_off_q) + AWIDTH'(k_q);
    assign pix_addr = AWIDTH'(ifm_off_q) + AWIDTH'(idy) * AWIDTH'(fm_q) + AWIDTH'(idx);
    assign out_addr = AWIDTH'(ofm_off_q) + AWIDTH'(y_q) * AWIDTH'(fm_q) + AWIDTH'(x_q);
    assign product = mem_resp_data * wt_q[k_q];

    always_comb begin
        state_d = state_q;
        fm_d = fm_q;
        wt_off_d = wt_off_q;
        ifm_off_d = ifm_off_q;
        ofm_off_d = ofm_off_q;
        k_d = k_q;
        m_d = m_q;
        n_d = n_q;
        x_d = x_q;
        y_d = y_q;
        acc_d = acc_q;
        wt_d = wt_q;
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        resp_ready_d = resp_ready_q;
        tap_step = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fm_d = fm_dim;
                    wt_off_d = wt_offset;
                    ifm_off_d = ifm_offset;
                    ofm_off_d = ofm_offset;
                    k_d = '0;
                    m_d = '0;
                    n_d = '0;
                    x_d = '0;
                    y_d = '0;
                    acc_d = '0;
                    state_d = S_LOAD_WT;
                end
            end
            S_LOAD_WT: begin
                if (!req_valid_q && !resp_ready_q) begin
                    req_valid_d = 1'b1;
                    req_write_d = 1'b0;
                    req_addr_d = wt_addr;
                end else if (req_valid_q && mem_req_ready) begin
                    req_valid_d = 1'b0;
                    resp_ready_d = 1'b1;
                end else if (resp_ready_q && mem_resp_valid) begin
                    resp_ready_d = 1'b0;
                    wt_d[k_q] = mem_resp_data;
                    if (k_q == LAST_TAP) begin
                        k_d = '0;
                        acc_d = '0;
                        state_d = (fm_q == '0) ? S_DONE : S_COMPUTE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                if (!req_valid_q && !resp_ready_q) begin
                    if (halo) begin
                        tap_step = 1'b1;
                    end else begin
                        req_valid_d = 1'b1;
                        req_write_d = 1'b0;
                        req_addr_d = pix_addr;
                    end
                end else if (req_valid_q && mem_req_ready) begin
                    req_valid_d = 1'b0;
                    resp_ready_d = 1'b1;
                end else if (resp_ready_q && mem_resp_valid) begin
                    resp_ready_d = 1'b0;
                    acc_d = acc_q + product;
                    tap_step = 1'b1;
                end
            end
            S_WRITE: begin
                if (!req_valid_q) begin
                    req_valid_d = 1'b1;
                    req_write_d = 1'b1;
                    req_addr_d = out_addr;
                    req_data_d = acc_q;
                end else if (mem_req_ready) begin
                    req_valid_d = 1'b0;
                    req_write_d = 1'b0;
                    acc_d = '0;
                    state_d = S_COMPUTE;
                    if (x_q == fm_q - 32'd1) begin
                        x_d = '0;
                        if (y_q == fm_q - 32'd1) begin
                            state_d = S_DONE;
                        end else begin
                            y_d = y_q + 32'd1;
                        end
                    end else begin
                        x_d = x_q + 32'd1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // n is the fast tap index; k tracks m*WT_DIM+n to select the weight without a multiply.
        if (tap_step) begin
            if (n_q == LAST_MN) begin
                n_d = '0;
                if (m_q == LAST_MN) begin
                    m_d = '0;
                    k_d = '0;
                    state_d = S_WRITE;
                end else begin
                    m_d = m_q + 1'b1;
                    k_d = k_q + 1'b1;
                end
            end else begin
                n_d = n_q + 1'b1;
                k_d = k_q + 1'b1;
            end
        end

        idle_d = (state_d == S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            fm_q <= '0;
            wt_off_q <= '0;
            ifm_off_q <= '0;
            ofm_off_q <= '0;
            k_q <= '0;
            m_q <= '0;
            n_q <= '0;
            x_q <= '0;
            y_q <= '0;
            acc_q <= '0;
            wt_q <= '{default: '0};
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            resp_ready_q <= 1'b0;
            idle_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fm_q <= fm_d;
            wt_off_q <= wt_off_d;
            ifm_off_q <= ifm_off_d;
            ofm_off_q <= ofm_off_d;
            k_q <= k_d;
            m_q <= m_d;
            n_q <= n_d;
            x_q <= x_d;
            y_q <= y_d;
            acc_q <= acc_d;
            wt_q <= wt_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            resp_ready_q <= resp_ready_d;
            idle_q <= idle_d;
            done_q <= done_d;
        end
    end

    assign idle = idle_q;
    assign done = done_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_write = req_write_q;
    assign mem_req_addr = req_addr_q;
    assign mem_req_data = req_data_q;
    assign mem_resp_ready = resp_ready_q;

`ifdef CONV2D_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q != S_IDLE) begin
            perf_d = perf_q + 32'd1;
        end else if (start) begin
            perf_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv2d_engine.sv
// Randomized self-checking bench for conv2d_engine: behavioural memory with optional stalls,
// and a loop-based convolution reference model computed from the memory image.
module tb_conv2d_engine;
    localparam int WT = 3;
    localparam int MEMW = 256;
    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        idle;
    logic        done;
    logic [31:0] fm_dim;
    logic [31:0] wt_offset;
    logic [31:0] ifm_offset;
    logic [31:0] ofm_offset;
    logic [31:0] mem_req_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_data;
    logic        mem_req_write;
    logic [31:0] mem_resp_data;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
`ifdef CONV2D_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    always #5 clk = ~clk;

    conv2d_engine #(.WT_DIM(WT), .DWIDTH(32), .AWIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .idle(idle),
        .done(done),
        .fm_dim(fm_dim),
        .wt_offset(wt_offset),
        .ifm_offset(ifm_offset),
        .ofm_offset(ofm_offset),
        .mem_req_addr(mem_req_addr),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_data(mem_req_data),
        .mem_req_write(mem_req_write),
        .mem_resp_data(mem_resp_data),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_ready(mem_resp_ready)
`ifdef CONV2D_PERF_CNT_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    logic [31:0] mem [MEMW];
    logic [31:0] exp_out [64];
    logic [31:0] saved_out [64];
    int exp_reads;
    int n_checks = 0;
    int n_fail = 0;

    bit stall_mode = 1'b0;
    int stall = 0;
    bit req_seen = 1'b0;
    bit pending = 1'b0;
    int lat = 0;
    logic [31:0] pend_data;
    int rd_cnt, wr_cnt, proto_err, stab_err;
    bit s_req, s_resp, s_write, prev_hold;
    logic [31:0] s_addr, s_data, p_addr, p_data;
    bit p_write;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Memory: decide handshakes from the values seen at negedge, update just after the posedge.
    initial begin : mem_model
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            s_req = mem_req_valid && mem_req_ready;
            s_resp = mem_resp_valid && mem_resp_ready;
            s_addr = mem_req_addr;
            s_data = mem_req_data;
            s_write = mem_req_write;
            if (!rst) begin
                if (mem_req_valid && pending) proto_err++;
                if (mem_resp_ready && !pending) proto_err++;
                if (mem_req_valid && mem_req_addr >= MEMW) proto_err++;
                if (prev_hold && (!mem_req_valid || mem_req_addr != p_addr ||
                                  mem_req_data != p_data || mem_req_write != p_write))
                    stab_err++;
            end
            prev_hold = !rst && mem_req_valid && !mem_req_ready;
            p_addr = mem_req_addr;
            p_data = mem_req_data;
            p_write = mem_req_write;
            @(posedge clk);
            #1;
            if (rst) begin
                pending = 1'b0;
                stall = 0;
                req_seen = 1'b0;
                mem_resp_valid = 1'b0;
                mem_req_ready = 1'b1;
            end else begin
                if (s_resp) pending = 1'b0;
                if (s_req) begin
                    req_seen = 1'b0;
                    if (s_write) begin
                        mem[s_addr[7:0]] = s_data;
                        wr_cnt++;
                    end else begin
                        pending = 1'b1;
                        pend_data = mem[s_addr[7:0]];
                        lat = stall_mode ? int'($urandom_range(0, 3)) : 0;
                        rd_cnt++;
                    end
                end
                if (pending) begin
                    if (lat == 0) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data = pend_data;
                    end else begin
                        lat--;
                        mem_resp_valid = 1'b0;
                        mem_resp_data = $urandom;
                    end
                end else begin
                    mem_resp_valid = stall_mode && ($urandom_range(0, 3) == 0);
                    mem_resp_data = $urandom;
                end
                if (stall > 0) stall--;
                if (stall_mode && mem_req_valid && !req_seen && !s_req) begin
                    req_seen = 1'b1;
                    if ($urandom_range(0, 2) == 0) stall = 5;
                end
                mem_req_ready = (stall == 0);
            end
        end
    end

    task automatic buildModel(input int fm, input int wo, input int io);
        logic [31:0] acc;
        int iy, ix;
        exp_reads = WT * WT;
        for (int y = 0; y < fm; y++) begin
            for (int x = 0; x < fm; x++) begin
                acc = '0;
                for (int m = 0; m < WT; m++) begin
                    for (int n = 0; n < WT; n++) begin
                        iy = y + m - WT / 2;
                        ix = x + n - WT / 2;
                        if (iy >= 0 && iy < fm && ix >= 0 && ix < fm) begin
                            acc = acc + mem[io + iy * fm + ix] * mem[wo + m * WT + n];
                            exp_reads++;
                        end
                    end
                end
                exp_out[y * fm + x] = acc;
            end
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < MEMW; i++) mem[i] = $urandom;
    endtask

    task automatic applyStimulus(input string name, input int fm, input int wo, input int io,
                                 input int oo, input int poke_at, input int abort_at);
        int cycles, busy_cnt, idle_bad;
        bit got_done;
        rd_cnt = 0;
        wr_cnt = 0;
        proto_err = 0;
        stab_err = 0;
        buildModel(fm, wo, io);
        @(negedge clk);
        fm_dim = fm;
        wt_offset = wo;
        ifm_offset = io;
        ofm_offset = oo;
        start = 1'b1;
        cycles = 0;
        busy_cnt = 0;
        idle_bad = 0;
        got_done = 1'b0;
        while (!got_done && cycles < LIMIT) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                start = 1'b0;
                fm_dim = $urandom;
                wt_offset = $urandom;
                ifm_offset = $urandom;
                ofm_offset = $urandom;
            end
            if (poke_at > 1 && cycles == poke_at) start = 1'b1;
            if (poke_at > 1 && cycles == poke_at + 1) start = 1'b0;
            if (!idle) busy_cnt++;
            if (done) got_done = 1'b1;
            else if (idle) idle_bad++;
            if (abort_at > 0 && cycles == abort_at) begin
                @(posedge clk);
                #2 rst = 1'b1;
                @(negedge clk);
                checkOutput({name, "_rst_idle"}, idle, 1);
                checkOutput({name, "_rst_req_valid"}, mem_req_valid, 0);
                checkOutput({name, "_rst_resp_ready"}, mem_resp_ready, 0);
                @(posedge clk);
                #2 rst = 1'b0;
                @(negedge clk);
                return;
            end
        end
        checkOutput({name, "_done_seen"}, got_done, 1);
        checkOutput({name, "_idle_low_in_run"}, idle_bad, 0);
        @(negedge clk);
        checkOutput({name, "_done_one_cycle"}, done, 0);
        checkOutput({name, "_idle_after"}, idle, 1);
        checkOutput({name, "_reads"}, rd_cnt, exp_reads);
        checkOutput({name, "_writes"}, wr_cnt, fm * fm);
        checkOutput({name, "_protocol"}, proto_err, 0);
        checkOutput({name, "_req_stable"}, stab_err, 0);
        for (int i = 0; i < fm * fm; i++)
            checkOutput($sformatf("%s_out[%0d]", name, i), mem[oo + i], exp_out[i]);
`ifdef CONV2D_PERF_CNT_EN
        checkOutput({name, "_perf"}, perf_cycles, busy_cnt);
        repeat (3) @(negedge clk);
        checkOutput({name, "_perf_hold"}, perf_cycles, busy_cnt);
`endif
    endtask

    task automatic setupPlan8();
        logic [31:0] w [9];
        w = '{1, 2, 1, 4, 5, 4, 1, 2, 1};
        fillRandom();
        for (int k = 0; k < 9; k++) mem[k] = w[k];
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) mem[9 + y * 8 + x] = x;
    endtask

    initial begin : stimulus
        int fm, wo, io, oo;
        rst = 1'b1;
        start = 1'b0;
        fm_dim = '0;
        wt_offset = '0;
        ifm_offset = '0;
        ofm_offset = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_idle", idle, 1);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_req_valid", mem_req_valid, 0);
        checkOutput("reset_req_write", mem_req_write, 0);
        checkOutput("reset_resp_ready", mem_resp_ready, 0);
`ifdef CONV2D_PERF_CNT_EN
        checkOutput("reset_perf", perf_cycles, 0);
`endif
        @(posedge clk);
        #2 rst = 1'b0;

        $display("[TB] 8x8 plan, single-cycle memory");
        setupPlan8();
        applyStimulus("plan", 8, 0, 9, 73, 0, 0);
        checkOutput("plan_out0", mem[73], 5);
        checkOutput("plan_out1", mem[74], 17);
        checkOutput("plan_out7", mem[80], 79);
        checkOutput("plan_out8", mem[81], 6);
        checkOutput("plan_out9", mem[82], 21);
        checkOutput("plan_out15", mem[88], 99);
        checkOutput("plan_out63", mem[136], 79);
        for (int i = 0; i < 64; i++) saved_out[i] = mem[73 + i];

        $display("[TB] 8x8 plan with stalls");
        setupPlan8();
        stall_mode = 1'b1;
        applyStimulus("stall", 8, 0, 9, 73, 0, 0);
        for (int i = 0; i < 64; i++)
            checkOutput($sformatf("stall_same[%0d]", i), mem[73 + i], saved_out[i]);

        $display("[TB] fm_dim=1");
        stall_mode = 1'b0;
        fillRandom();
        for (int k = 0; k < 9; k++) mem[100 + k] = 0;
        mem[104] = 5;
        mem[120] = 3;
        applyStimulus("fm1", 1, 100, 120, 130, 0, 0);
        checkOutput("fm1_pixel_reads", rd_cnt - 9, 1);
        checkOutput("fm1_result", mem[130], 15);

        $display("[TB] fm_dim=0");
        fillRandom();
        applyStimulus("fm0", 0, 0, 16, 128, 0, 0);

        $display("[TB] start pulsed mid-run");
        stall_mode = 1'b1;
        fillRandom();
        applyStimulus("poke", 5, 2, 20, 140, 60, 0);

        $display("[TB] reset mid-run then fresh run");
        fillRandom();
        applyStimulus("abort", 6, 0, 16, 128, 0, 45);
        fillRandom();
        applyStimulus("after_rst", 6, 3, 24, 150, 0, 0);

        $display("[TB] all-zero weights");
        stall_mode = 1'b0;
        fillRandom();
        for (int k = 0; k < 9; k++) mem[k] = 0;
        applyStimulus("zero_wt", 8, 0, 16, 128, 0, 0);
        checkOutput("zero_wt_out0", mem[128], 0);
        checkOutput("zero_wt_out63", mem[191], 0);

        for (int r = 0; r < 3; r++) begin
            stall_mode = r[0];
            fillRandom();
            fm = $urandom_range(2, 7);
            wo = $urandom_range(0, 6);
            io = 16 + $urandom_range(0, 8);
            oo = 128 + $urandom_range(0, 60);
            $display("[TB] random run %0d fm=%0d", r, fm);
            applyStimulus($sformatf("rand%0d", r), fm, wo, io, oo, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
